round_sched: RTL and testbench
==============================

Name: round_sched

Overview:
- Shares one instance of the team's round unit between the sin and cos result channels of the fsincos core.
- Inputs are 8-bit signed exponent / 40-bit fraction pairs. Outputs are rounded 8-bit exponent / 32-bit fraction pairs.
- Round-robin arbitration, two-stage valid/ready pipeline, and a drain mode that parks the block cleanly before mode or precision changes.
- Sits between the CORDIC post-normalisers and the result packer.

Parameters:
- EXP_WIDTH, 8: exponent width; passed to the round unit.
- FRAC_WIDTH, 40: unrounded fraction width; passed to the round unit. Output fraction is fixed at 32 bits.
- TAG_WIDTH, 4: width of the opaque transaction tag carried alongside each operand.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous reset, active-high.
- i_sin_valid  in  1  sin channel operand valid.
- o_sin_ready  out  1  sin channel accept.
- i_sin_exp  in  EXP_WIDTH  sin exponent, signed.
- i_sin_frac  in  FRAC_WIDTH  sin unrounded fraction.
- i_sin_tag  in  TAG_WIDTH  sin tag.
- i_cos_valid, o_cos_ready, i_cos_exp, i_cos_frac, i_cos_tag: same as the sin channel, for cos.
- o_valid  out  1  rounded result valid.
- i_ready  in  1  downstream accept.
- o_exp  out  EXP_WIDTH  rounded exponent, signed.
- o_frac  out  32  rounded fraction.
- o_tag  out  TAG_WIDTH  tag of the result.
- o_chan  out  1  source channel: 0 = sin, 1 = cos.
- i_drain  in  1  level; stop accepting new operands.
- o_idle  out  1  high when both stages are empty.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high on i_rst.
- Reset values: o_valid=0, o_exp=0, o_frac=0, o_tag=0, o_chan=0, o_idle=1. Internal: rr pointer=0 (sin preferred), both stage-valid bits=0, state=RUN.
- Reset mid-operation: all in-flight results are discarded; nothing is emitted afterwards.
- Stage 1 (S1): operand register holding {exp, frac, tag, chan}.
- S1 acceptance: S1 loads when it is empty, or when it advances into S2 in the same cycle.
- Stage 2 (S2): output register. It captures the round unit result computed from the S1 contents.
- S2 advance: S2 loads when empty or when o_valid & i_ready.
- Latency: an operand accepted in cycle N appears on o_valid in cycle N+2 if there is no backpressure.
- Throughput: one result per cycle under sustained i_ready=1.
- Ready is combinational from the grant: o_X_ready = grant_X & s1_can_load & (state==RUN).
- Ready is independent of the requester's own valid beyond arbitration.
- Arbitration: if only one channel is valid, it is granted.
- If both are valid, the channel the rr pointer favours is granted. The pointer flips to the other channel only on an accepted transfer.
- A channel with valid high must hold its payload until accepted (standard valid/ready rules).
- Round function, applied combinationally between S1 and S2:
  - STK = |frac[6:0], G = frac[8], R = frac[7].
  - rnd = R & (G | STK).
  - sum = {1'b0, frac} + rnd.
  - If sum[40]: o_frac = sum[40:9] and exp+1.
  - Otherwise: o_frac = sum[39:8] and exp unchanged.
  - Exponent arithmetic wraps modulo 2^EXP_WIDTH (see optional feature).
- Output hold: while o_valid=1 and i_ready=0, o_exp/o_frac/o_tag/o_chan are held stable.
- States: RUN and DRAIN.
  - RUN -> DRAIN when i_drain=1.
  - DRAIN -> RUN when i_drain=0.
  - In DRAIN both readies are 0, and S1/S2 keep flushing to the output.
- o_idle = !s1_valid & !s2_valid, registered with a 1-cycle lag from the last handshake.
- Simultaneous events: i_drain rising in the same cycle as a would-be accept blocks that accept, because ready is gated combinationally.

Optional Feature:
- Macro: ROUND_SCHED_OVF_EN.
- Defined:
  - Adds output port o_ovf (1 bit, reset 0), registered alongside S2.
  - o_ovf=1 when the round carry increments exp from +(2^(EXP_WIDTH-1))-1.
  - In that case o_exp saturates to +(2^(EXP_WIDTH-1))-1 and o_frac = 32'hFFFF_FFFF.
- Undefined: no port; the exponent wraps (127+1 -> -128).

Test Plan:
- Reset/idle: i_rst=1 for 2 cycles, then release -> o_valid=0, o_idle=1, o_sin_ready=1, o_cos_ready=0.
- Single sin operand: exp=5, frac=40'h12_3456_7880, tag=3, accepted at cycle N -> at N+2: o_valid=1, o_exp=5, o_frac=32'h1234_5678, o_tag=3, o_chan=0.
- Carry path: cos operand exp=10, frac=40'hFF_FFFF_FFFF -> o_exp=11, o_frac=32'h8000_0000, o_chan=1.
- Contention: both channels valid for 6 cycles, i_ready=1 -> o_chan sequence 0,1,0,1,0,1; throughput 1 per cycle.
- Backpressure and drain: i_ready=0 for 4 cycles with both channels valid -> both readies drop after S1 and S2 fill, outputs stay stable. Then assert i_drain and i_ready=1 -> 2 results emitted, o_idle=1 one cycle after the last handshake, no further accepts.
- Overflow: exp=127, frac=40'hFF_FFFF_FFFF -> with ROUND_SCHED_OVF_EN: o_ovf=1, o_exp=127, o_frac=32'hFFFF_FFFF. Without it: o_exp=-128, o_frac=32'h8000_0000.

Source files
------------

// File: rtl/round_sched.sv
// Shares one round unit between the sin and cos result channels: round-robin grant, two-stage valid/ready pipe, drain mode.
// Optional macro ROUND_SCHED_OVF_EN adds o_ovf and saturates the exponent when the round carry overflows it.

module round_sched_round_unit #(
    parameter int EXP_WIDTH  = 8,
    parameter int FRAC_WIDTH = 40
) (
    input  logic [EXP_WIDTH-1:0]  i_exp,
    input  logic [FRAC_WIDTH-1:0] i_frac,
`ifdef ROUND_SCHED_OVF_EN
    output logic                  o_ovf,
`endif
    output logic [EXP_WIDTH-1:0]  o_exp,
    output logic [31:0]           o_frac
);
    localparam int DROP = FRAC_WIDTH - 32;
    localparam logic [EXP_WIDTH-1:0] EXP_MAX = {1'b0, {(EXP_WIDTH-1){1'b1}}};

    logic                stk;
    logic                g;
    logic                r;
    logic                rnd;
    logic [FRAC_WIDTH:0] sum;
    logic                unused_low;

    always_comb begin
        stk    = |i_frac[DROP-2:0];
        g      = i_frac[DROP];
        r      = i_frac[DROP-1];
        rnd    = r & (g | stk);
        sum    = {1'b0, i_frac} + {{FRAC_WIDTH{1'b0}}, rnd};
        o_exp  = i_exp;
        o_frac = sum[FRAC_WIDTH-1:DROP];
`ifdef ROUND_SCHED_OVF_EN
        o_ovf  = 1'b0;
`endif
        if (sum[FRAC_WIDTH]) begin
            o_exp  = i_exp + EXP_WIDTH'(1);
            o_frac = sum[FRAC_WIDTH:DROP+1];
`ifdef ROUND_SCHED_OVF_EN
            if (i_exp == EXP_MAX) begin
                o_ovf  = 1'b1;
                o_exp  = EXP_MAX;
                o_frac = '1;
            end
`endif
        end
    end

    assign unused_low = ^sum[DROP-1:0];
endmodule

module round_sched #(
    parameter int EXP_WIDTH  = 8,
    parameter int FRAC_WIDTH = 40,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_sin_valid,
    output logic                  o_sin_ready,
    input  logic [EXP_WIDTH-1:0]  i_sin_exp,
    input  logic [FRAC_WIDTH-1:0] i_sin_frac,
    input  logic [TAG_WIDTH-1:0]  i_sin_tag,
    input  logic                  i_cos_valid,
    output logic                  o_cos_ready,
    input  logic [EXP_WIDTH-1:0]  i_cos_exp,
    input  logic [FRAC_WIDTH-1:0] i_cos_frac,
    input  logic [TAG_WIDTH-1:0]  i_cos_tag,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [EXP_WIDTH-1:0]  o_exp,
    output logic [31:0]           o_frac,
    output logic [TAG_WIDTH-1:0]  o_tag,
    output logic                  o_chan,
    input  logic                  i_drain,
`ifdef ROUND_SCHED_OVF_EN
    output logic                  o_ovf,
`endif
    output logic                  o_idle
);
    typedef enum logic {RUN, DRAIN} state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  accept_open;
    logic                  rr;
    logic                  grant_cos;
    logic                  s2_can_load;
    logic                  s1_can_load;
    logic                  sin_fire;
    logic                  cos_fire;
    logic                  accept;

    logic                  s1_valid;
    logic [EXP_WIDTH-1:0]  s1_exp;
    logic [FRAC_WIDTH-1:0] s1_frac;
    logic [TAG_WIDTH-1:0]  s1_tag;
    logic                  s1_chan;

    logic [EXP_WIDTH-1:0]  rnd_exp;
    logic [31:0]           rnd_frac;
`ifdef ROUND_SCHED_OVF_EN
    logic                  rnd_ovf;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= RUN;
        else       state <= state_nxt;
    end

    // Accept is also blocked by i_drain itself so a drain request wins over a same-cycle accept.
    always_comb begin
        state_nxt   = state;
        accept_open = 1'b0;
        case (state)
            RUN: begin
                accept_open = !i_drain;
                if (i_drain) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!i_drain) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    // A lone requester is granted; contention or no request falls back to the rr pointer.
    always_comb begin
        grant_cos   = (i_sin_valid ^ i_cos_valid) ? i_cos_valid : rr;
        s2_can_load = !o_valid || i_ready;
        s1_can_load = !s1_valid || s2_can_load;
        o_sin_ready = !grant_cos && s1_can_load && accept_open;
        o_cos_ready = grant_cos && s1_can_load && accept_open;
        sin_fire    = i_sin_valid && o_sin_ready;
        cos_fire    = i_cos_valid && o_cos_ready;
        accept      = sin_fire || cos_fire;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)       rr <= 1'b0;
        else if (accept) rr <= sin_fire;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_exp   <= '0;
            s1_frac  <= '0;
            s1_tag   <= '0;
            s1_chan  <= 1'b0;
        end else if (s1_can_load) begin
            s1_valid <= accept;
            if (accept) begin
                s1_chan <= cos_fire;
                s1_exp  <= cos_fire ? i_cos_exp  : i_sin_exp;
                s1_frac <= cos_fire ? i_cos_frac : i_sin_frac;
                s1_tag  <= cos_fire ? i_cos_tag  : i_sin_tag;
            end
        end
    end

    round_sched_round_unit #(
        .EXP_WIDTH  (EXP_WIDTH),
        .FRAC_WIDTH (FRAC_WIDTH)
    ) u_round (
        .i_exp  (s1_exp),
        .i_frac (s1_frac),
`ifdef ROUND_SCHED_OVF_EN
        .o_ovf  (rnd_ovf),
`endif
        .o_exp  (rnd_exp),
        .o_frac (rnd_frac)
    );

    // Output data only moves when S1 supplies a result, so it holds under backpressure.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_exp   <= '0;
            o_frac  <= '0;
            o_tag   <= '0;
            o_chan  <= 1'b0;
`ifdef ROUND_SCHED_OVF_EN
            o_ovf   <= 1'b0;
`endif
        end else if (s2_can_load) begin
            o_valid <= s1_valid;
            if (s1_valid) begin
                o_exp  <= rnd_exp;
                o_frac <= rnd_frac;
                o_tag  <= s1_tag;
                o_chan <= s1_chan;
`ifdef ROUND_SCHED_OVF_EN
                o_ovf  <= rnd_ovf;
`endif
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) o_idle <= 1'b1;
        else       o_idle <= !s1_valid && !o_valid;
    end
endmodule

// File: tb/tb_round_sched.sv
// Self-checking bench for round_sched: vector table, directed corner sequences, randomized run against a queue model.
// Honours ROUND_SCHED_OVF_EN the same way as the design.

module tb_round_sched;
    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_sin_valid, o_sin_ready;
    logic [7:0]  i_sin_exp;
    logic [39:0] i_sin_frac;
    logic [3:0]  i_sin_tag;
    logic        i_cos_valid, o_cos_ready;
    logic [7:0]  i_cos_exp;
    logic [39:0] i_cos_frac;
    logic [3:0]  i_cos_tag;
    logic        o_valid, i_ready;
    logic [7:0]  o_exp;
    logic [31:0] o_frac;
    logic [3:0]  o_tag;
    logic        o_chan, i_drain, o_idle;
`ifdef ROUND_SCHED_OVF_EN
    logic        o_ovf;
`endif

    always #5 clk = ~clk;

    round_sched #(
        .EXP_WIDTH  (8),
        .FRAC_WIDTH (40),
        .TAG_WIDTH  (4)
    ) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_sin_valid (i_sin_valid),
        .o_sin_ready (o_sin_ready),
        .i_sin_exp   (i_sin_exp),
        .i_sin_frac  (i_sin_frac),
        .i_sin_tag   (i_sin_tag),
        .i_cos_valid (i_cos_valid),
        .o_cos_ready (o_cos_ready),
        .i_cos_exp   (i_cos_exp),
        .i_cos_frac  (i_cos_frac),
        .i_cos_tag   (i_cos_tag),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_exp       (o_exp),
        .o_frac      (o_frac),
        .o_tag       (o_tag),
        .o_chan      (o_chan),
        .i_drain     (i_drain),
`ifdef ROUND_SCHED_OVF_EN
        .o_ovf       (o_ovf),
`endif
        .o_idle      (o_idle)
    );

    typedef struct {
        logic        chan;
        logic [7:0]  exp;
        logic [39:0] frac;
        logic [3:0]  tag;
        logic [7:0]  r_exp;
        logic [31:0] r_frac;
        logic        r_ovf;
    } vec_t;

    typedef struct {
        logic [7:0]  exp;
        logic [39:0] frac;
        logic [3:0]  tag;
        logic        chan;
        int          acc;
    } item_t;

    typedef struct packed {
        logic [7:0]  exp;
        logic [31:0] frac;
        logic        ovf;
    } res_t;

    int    checks = 0;
    int    errors = 0;
    vec_t  vt[6];
    item_t q[$];
    item_t it;
    res_t  rr_res;
    int    cyc, last_pop, n_prev;
    logic  rr_m, drain_prev, g_cos, room, open_m, e_sin_rdy, e_cos_rdy, e_valid, pop, acc_sin, acc_cos;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference rounding written from the arithmetic rule with plain integers.
    function automatic res_t ref_round(input logic [7:0] e, input logic [39:0] f);
        res_t        r;
        logic [40:0] s;
        logic        rnd;
        int          ev;
        rnd   = f[7] && (f[8] || (f[6:0] != 7'd0));
        s     = {1'b0, f} + 41'(rnd);
        ev    = int'($signed(e));
        r.ovf = 1'b0;
        if (s[40]) begin
            r.frac = s[40:9];
            ev     = ev + 1;
        end else begin
            r.frac = s[39:8];
        end
        if (ev > 127) begin
`ifdef ROUND_SCHED_OVF_EN
            r.ovf  = 1'b1;
            ev     = 127;
            r.frac = 32'hFFFF_FFFF;
`else
            ev = ev - 256;
`endif
        end
        r.exp = ev[7:0];
        return r;
    endfunction

    function automatic logic [39:0] rand_frac();
        logic [39:0] f;
        f = {8'($urandom), 32'($urandom)};
        case ($urandom_range(0, 3))
            0: f = 40'hFF_FFFF_FFFF;
            1: f[8:0] = 9'($urandom_range(0, 3) == 0 ? 9'h180 : 9'h07F + 9'($urandom_range(0, 2)));
            default: ;
        endcase
        return f;
    endfunction

    function automatic logic [7:0] rand_exp();
        return ($urandom_range(0, 3) == 0) ? 8'h7F : 8'($urandom);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        i_rst = 1'b1;
        i_sin_valid = 1'b0; i_cos_valid = 1'b0;
        i_ready = 1'b0; i_drain = 1'b0;
        tick();
        tick();
        i_rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        i_sin_exp = '0; i_sin_frac = '0; i_sin_tag = '0;
        i_cos_exp = '0; i_cos_frac = '0; i_cos_tag = '0;
        vt[0] = '{1'b0, 8'd5,   40'h12_3456_7880, 4'd3,  8'd5,   32'h1234_5678, 1'b0};
        vt[1] = '{1'b1, 8'd10,  40'hFF_FFFF_FFFF, 4'd9,  8'd11,  32'h8000_0000, 1'b0};
`ifdef ROUND_SCHED_OVF_EN
        vt[2] = '{1'b0, 8'h7F,  40'hFF_FFFF_FFFF, 4'd5,  8'h7F,  32'hFFFF_FFFF, 1'b1};
`else
        vt[2] = '{1'b0, 8'h7F,  40'hFF_FFFF_FFFF, 4'd5,  8'h80,  32'h8000_0000, 1'b0};
`endif
        vt[3] = '{1'b1, 8'h80,  40'h00_0000_01FF, 4'd1,  8'h80,  32'h0000_0002, 1'b0};
        vt[4] = '{1'b0, 8'hFF,  40'hAB_CDEF_0181, 4'd15, 8'hFF,  32'hABCD_EF01, 1'b0};
        vt[5] = '{1'b1, 8'h7F,  40'h7F_FFFF_FF80, 4'd7,  8'h7F,  32'h7FFF_FFFF, 1'b0};

        @(posedge clk); #1;
        reset_dut();
        @(negedge clk);
        check("rst_valid", o_valid, 1'b0);
        check("rst_idle", o_idle, 1'b1);
        check("rst_sin_ready", o_sin_ready, 1'b1);
        check("rst_cos_ready", o_cos_ready, 1'b0);
        check("rst_exp", o_exp, 8'd0);
        check("rst_frac", o_frac, 32'd0);
        check("rst_tag", o_tag, 4'd0);
        check("rst_chan", o_chan, 1'b0);
        tick();

        // Single-operand vectors: accept, one empty cycle, then result.
        i_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (vt[i].chan) begin
                i_cos_valid = 1'b1; i_cos_exp = vt[i].exp; i_cos_frac = vt[i].frac; i_cos_tag = vt[i].tag;
            end else begin
                i_sin_valid = 1'b1; i_sin_exp = vt[i].exp; i_sin_frac = vt[i].frac; i_sin_tag = vt[i].tag;
            end
            @(negedge clk);
            check($sformatf("tbl%0d_ready", i), vt[i].chan ? o_cos_ready : o_sin_ready, 1'b1);
            tick();
            i_sin_valid = 1'b0; i_cos_valid = 1'b0;
            @(negedge clk);
            check($sformatf("tbl%0d_lat1_valid", i), o_valid, 1'b0);
            tick();
            @(negedge clk);
            check($sformatf("tbl%0d_valid", i), o_valid, 1'b1);
            check($sformatf("tbl%0d_exp", i), o_exp, vt[i].r_exp);
            check($sformatf("tbl%0d_frac", i), o_frac, vt[i].r_frac);
            check($sformatf("tbl%0d_tag", i), o_tag, vt[i].tag);
            check($sformatf("tbl%0d_chan", i), o_chan, vt[i].chan);
`ifdef ROUND_SCHED_OVF_EN
            check($sformatf("tbl%0d_ovf", i), o_ovf, vt[i].r_ovf);
`endif
            tick();
        end

        // Contention: alternating grants, one result per cycle.
        reset_dut();
        i_ready = 1'b1;
        i_sin_exp = 8'd1; i_sin_frac = 40'h00_0000_0100; i_sin_tag = 4'd1;
        i_cos_exp = 8'd2; i_cos_frac = 40'h00_0000_0200; i_cos_tag = 4'd2;
        for (int k = 0; k < 12; k++) begin
            i_sin_valid = (k < 6); i_cos_valid = (k < 6);
            @(negedge clk);
            if (k < 6) begin
                check($sformatf("cont%0d_sin_ready", k), o_sin_ready, (k % 2 == 0));
                check($sformatf("cont%0d_cos_ready", k), o_cos_ready, (k % 2 == 1));
            end
            check($sformatf("cont%0d_valid", k), o_valid, (k >= 2 && k <= 7));
            if (k >= 2 && k <= 7) begin
                check($sformatf("cont%0d_chan", k), o_chan, ((k - 2) % 2 == 1));
                check($sformatf("cont%0d_frac", k), o_frac, ((k - 2) % 2 == 1) ? 32'd2 : 32'd1);
            end
            tick();
        end

        // Backpressure fills both stages, then drain flushes exactly two results.
        reset_dut();
        i_sin_exp = 8'd3; i_sin_frac = 40'h01_0203_0400; i_sin_tag = 4'hA;
        i_cos_exp = 8'd4; i_cos_frac = 40'h05_0607_0800; i_cos_tag = 4'hB;
        i_sin_valid = 1'b1; i_cos_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k >= 4) begin i_drain = 1'b1; i_ready = 1'b1; end
            @(negedge clk);
            check($sformatf("bp%0d_sin_ready", k), o_sin_ready, (k == 0));
            check($sformatf("bp%0d_cos_ready", k), o_cos_ready, (k == 1));
            if (k >= 2 && k <= 4) begin
                check($sformatf("bp%0d_valid", k), o_valid, 1'b1);
                check($sformatf("bp%0d_chan", k), o_chan, 1'b0);
                check($sformatf("bp%0d_tag", k), o_tag, 4'hA);
                check($sformatf("bp%0d_exp", k), o_exp, 8'd3);
                check($sformatf("bp%0d_frac", k), o_frac, 32'h0102_0304);
            end
            if (k == 5) begin
                check("bp5_valid", o_valid, 1'b1);
                check("bp5_chan", o_chan, 1'b1);
                check("bp5_tag", o_tag, 4'hB);
                check("bp5_frac", o_frac, 32'h0506_0708);
            end
            if (k >= 6) check($sformatf("bp%0d_valid", k), o_valid, 1'b0);
            if (k == 4) check("bp4_idle", o_idle, 1'b0);
            if (k >= 7) check($sformatf("bp%0d_idle", k), o_idle, 1'b1);
            tick();
        end
        i_drain = 1'b0; i_sin_valid = 1'b0; i_cos_valid = 1'b0;
        tick();

        // Reset with results in flight: nothing may emerge afterwards.
        reset_dut();
        i_sin_valid = 1'b1; i_sin_tag = 4'h6;
        tick();
        tick();
        i_sin_valid = 1'b0;
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0; i_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("midrst%0d_valid", k), o_valid, 1'b0);
            check($sformatf("midrst%0d_idle", k), o_idle, 1'b1);
            tick();
        end

        // Randomized run against an in-flight queue model.
        reset_dut();
        q.delete();
        rr_m = 1'b0; drain_prev = 1'b0; last_pop = -10; n_prev = 0; cyc = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (i_sin_valid && i_cos_valid)      g_cos = rr_m;
            else if (i_sin_valid || i_cos_valid) g_cos = i_cos_valid;
            else                                 g_cos = rr_m;
            room      = (q.size() < 2) || i_ready;
            open_m    = !i_drain && !drain_prev;
            e_sin_rdy = !g_cos && room && open_m;
            e_cos_rdy = g_cos && room && open_m;
            e_valid   = (q.size() > 0) && (cyc >= q[0].acc + 2) && (cyc >= last_pop + 1);
            check("rnd_sin_ready", o_sin_ready, e_sin_rdy);
            check("rnd_cos_ready", o_cos_ready, e_cos_rdy);
            check("rnd_valid", o_valid, e_valid);
            check("rnd_idle", o_idle, (n_prev == 0));
            if (e_valid) begin
                rr_res = ref_round(q[0].exp, q[0].frac);
                check("rnd_exp", o_exp, rr_res.exp);
                check("rnd_frac", o_frac, rr_res.frac);
                check("rnd_tag", o_tag, q[0].tag);
                check("rnd_chan", o_chan, q[0].chan);
`ifdef ROUND_SCHED_OVF_EN
                check("rnd_ovf", o_ovf, rr_res.ovf);
`endif
            end
            pop     = e_valid && i_ready;
            acc_sin = i_sin_valid && e_sin_rdy;
            acc_cos = i_cos_valid && e_cos_rdy;
            tick();
            n_prev = q.size();
            if (pop) begin
                void'(q.pop_front());
                last_pop = cyc;
            end
            if (acc_sin) begin
                it = '{i_sin_exp, i_sin_frac, i_sin_tag, 1'b0, cyc};
                q.push_back(it);
                rr_m = 1'b1;
            end
            if (acc_cos) begin
                it = '{i_cos_exp, i_cos_frac, i_cos_tag, 1'b1, cyc};
                q.push_back(it);
                rr_m = 1'b0;
            end
            drain_prev = i_drain;
            cyc++;
            if (!i_sin_valid || acc_sin) begin
                i_sin_valid = ($urandom_range(0, 99) < 60);
                i_sin_exp   = rand_exp();
                i_sin_frac  = rand_frac();
                i_sin_tag   = 4'($urandom);
            end
            if (!i_cos_valid || acc_cos) begin
                i_cos_valid = ($urandom_range(0, 99) < 60);
                i_cos_exp   = rand_exp();
                i_cos_frac  = rand_frac();
                i_cos_tag   = 4'($urandom);
            end
            i_ready = ($urandom_range(0, 99) < 70);
            i_drain = ($urandom_range(0, 99) < 10);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
